rgb_fp_prep: RTL and testbench
==============================

// Module: rgb_fp_prep
// PURPOSE
//  Pipelined front end of the RGB->HSV path. Takes one unsigned integer RGB pixel per cycle
//  and emits IEEE-754 single-precision R, G, B, Cmax, Cmin and delta (Cmax-Cmin).
//  These are the operands the hue/saturation FP stages consume directly.
//  All outputs are in channel scale (0..2^CH_W-1), not divided by 255.
//  H and S are scale-invariant. V normalisation is done downstream.
// PARAMETERS
//  CH_W   8   unsigned channel width in bits; legal range 1..24, so every value is exact in FP32
// PORTS
//  clk        in   1     single clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     input pixel valid
//  in_ready   out  1     block accepts the pixel this cycle
//  in_r       in   CH_W  red channel, unsigned
//  in_g       in   CH_W  green channel, unsigned
//  in_b       in   CH_W  blue channel, unsigned
//  out_valid  out  1     output bundle valid
//  out_ready  in   1     downstream accepts the bundle
//  r_fp       out  32    FP32 of in_r
//  g_fp       out  32    FP32 of in_g
//  b_fp       out  32    FP32 of in_b
//  cmax_fp    out  32    FP32 of max(r,g,b)
//  cmin_fp    out  32    FP32 of min(r,g,b)
//  delta_fp   out  32    FP32 of max-min
//  cmax_sel   out  2     only with RGB_PREP_MAXSEL_EN: 2'd0=R, 2'd1=G, 2'd2=B
// BEHAVIOUR
//  - Two register stages.
//    S1: integer capture plus max/min/delta; delta never underflows since max>=min.
//    S2: int->FP32 conversion of all six values.
//  - Handshake: a transfer occurs when valid&&ready.
//    adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1.
//    in_ready is combinational from out_ready; no skid buffer.
//  - Latency is 2 cycles from input transfer to out_valid when out_ready stays high.
//    Throughput is 1 pixel/clk.
//  - Stall: while out_valid && !out_ready, every output holds stable and S1 holds if full.
//    No pixel is dropped or duplicated.
//  - Conversion: 0 -> 32'h0000_0000 (+0, never -0).
//    Otherwise sign=0, exp=127+msb_index, mantissa = bits below the MSB, left-justified.
//    Examples: 1->3F800000, 60->42700000, 255->437F0000.
//  - Equal channels (max==min): delta_fp = 32'h0, cmax_fp == cmin_fp.
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, all data registers=0, cmax_sel=0.
//    Reset mid-stream discards in-flight pixels.
//    in_ready=1 in the first cycle after rst deasserts.
//  - Data registers load only on stage advance, not on bubbles.
// CONFIGURATION
//  RGB_PREP_MAXSEL_EN defined:
//    - Adds the cmax_sel port, pipelined alongside the data.
//    - Tie priority is R>G>B, matching the hue-case priority.
//    - Lets downstream select the hue branch without FP equality compares.
//  RGB_PREP_MAXSEL_EN undefined:
//    - No cmax_sel port, no extra flops; all other behaviour identical.
// STRUCTURE
//  - Shared package: FP32 constants (FP32_ZERO, FP32_BIAS=127, EXP_W=8, MAN_W=23)
//    and the cmax_sel encodings.
//  - One sub-module: u_to_fp32 (combinational, CH_W-bit unsigned -> FP32, priority-encoder
//    based), instantiated six times in S2.
//  - Top holds the two stage registers and the handshake.
// TESTING
//  1 (255,0,0), out_ready=1 -> after 2 clk:
//    cmax=437F0000, cmin=0, delta=437F0000, r=437F0000, sel=0.
//  2 (0,0,0) -> r=g=b=cmax=cmin=delta=00000000, sel=0.
//  3 (10,200,200) -> cmax=43480000, cmin=41200000, delta=433E0000, sel=1 (G wins G/B tie).
//  4 Stream of 8 pixels, out_ready low for 3 cycles mid-stream:
//    outputs frozen while stalled, in_ready low once both stages are full,
//    all 8 bundles emerge in order.
//  5 Assert rst with 2 pixels in flight -> out_valid=0 next cycle, those pixels never appear,
//    next input appears 2 clk after acceptance.
//  6 Sweep all 256 values on one channel, others 0 -> output equals the reference
//    int->FP32 model bit-exactly.

Source files
------------

// File: rtl/rgb_fp_prep_pkg.sv
// Shared constants for the RGB->HSV FP front end: FP32 field layout,
// cmax_sel encodings and the slot order of the six converted values.
package rgb_fp_prep_pkg;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam int          FP32_BIAS = 127;
    localparam int          EXP_W     = 8;
    localparam int          MAN_W     = 23;

    // Which channel supplied Cmax; tie priority is R > G > B.
    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } cmax_sel_e;

    // Slot order of the six values carried through the pipeline.
    localparam int NUM_VALS  = 6;
    localparam int IDX_R     = 0;
    localparam int IDX_G     = 1;
    localparam int IDX_B     = 2;
    localparam int IDX_CMAX  = 3;
    localparam int IDX_CMIN  = 4;
    localparam int IDX_DELTA = 5;

endpackage

// File: rtl/rgb_fp_prep_to_fp32.sv
// Combinational unsigned CH_W-bit integer -> IEEE-754 single conversion.
// CH_W <= 24 keeps every input exactly representable, so no rounding.
module rgb_fp_prep_to_fp32
    import rgb_fp_prep_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic [CH_W-1:0] val,
    output logic [31:0]     fp
);

    logic [4:0]       msb;
    logic [23:0]      ext;
    logic [23:0]      shifted;
    logic [EXP_W-1:0] exp_f;

    // Priority encoder for the MSB, then left-justify the bits below it.
    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < CH_W; i++) begin
            if (val[i]) msb = 5'(i);
        end
        ext     = 24'(val);
        shifted = ext << (5'd23 - msb);
        exp_f   = EXP_W'(FP32_BIAS) + EXP_W'(msb);
        if (val == '0) fp = FP32_ZERO;
        else           fp = {1'b0, exp_f, shifted[MAN_W-1:0]};
    end

endmodule

// File: rtl/rgb_fp_prep.sv
// Two-stage RGB pixel -> FP32 operand prep for the hue/saturation path.
// S1 captures the integer channels plus max/min/delta, S2 holds their FP32
// images. Backpressure ripples combinationally from out_ready to in_ready.
// Optional feature: define RGB_PREP_MAXSEL_EN to add the cmax_sel output.
module rgb_fp_prep
    import rgb_fp_prep_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_r,
    input  logic [CH_W-1:0] in_g,
    input  logic [CH_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     r_fp,
    output logic [31:0]     g_fp,
    output logic [31:0]     b_fp,
    output logic [31:0]     cmax_fp,
    output logic [31:0]     cmin_fp,
    output logic [31:0]     delta_fp
`ifdef RGB_PREP_MAXSEL_EN
    ,
    output logic [1:0]      cmax_sel
`endif
);

    logic s1_valid, s2_valid;
    logic adv1, adv2;

    logic [CH_W-1:0] mx, mn;
    logic [NUM_VALS-1:0][CH_W-1:0] s1_vals;
    logic [NUM_VALS-1:0][31:0]     fp_n;
    logic [NUM_VALS-1:0][31:0]     s2_fp;

    // A stage advances when its downstream slot is empty or being drained.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Max/min of the incoming pixel; max >= min, so delta cannot underflow.
    always_comb begin
        mx = in_r;
        mn = in_r;
        if (in_g > mx) mx = in_g;
        if (in_b > mx) mx = in_b;
        if (in_g < mn) mn = in_g;
        if (in_b < mn) mn = in_b;
    end

`ifdef RGB_PREP_MAXSEL_EN
    cmax_sel_e sel_n, s1_sel, s2_sel;

    // Channel that supplied Cmax, ties resolved R > G > B like the hue cases.
    always_comb begin
        if (in_r >= in_g && in_r >= in_b) sel_n = SEL_R;
        else if (in_g >= in_b)            sel_n = SEL_G;
        else                              sel_n = SEL_B;
    end

    // Channel select rides alongside the data through both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sel <= SEL_R;
            s2_sel <= SEL_R;
        end else begin
            if (adv1 && in_valid) s1_sel <= sel_n;
            if (adv2 && s1_valid) s2_sel <= s1_sel;
        end
    end

    assign cmax_sel = s2_sel;
`endif

    // S1: integer capture; data loads only when a real pixel is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_vals  <= '0;
        end else begin
            if (adv1) s1_valid <= in_valid;
            if (adv1 && in_valid) begin
                s1_vals[IDX_R]     <= in_r;
                s1_vals[IDX_G]     <= in_g;
                s1_vals[IDX_B]     <= in_b;
                s1_vals[IDX_CMAX]  <= mx;
                s1_vals[IDX_CMIN]  <= mn;
                s1_vals[IDX_DELTA] <= mx - mn;
            end
        end
    end

    // One converter per carried value, feeding the S2 register.
    for (genvar i = 0; i < NUM_VALS; i++) begin : g_cvt
        rgb_fp_prep_to_fp32 #(.CH_W(CH_W)) u_to_fp32 (
            .val (s1_vals[i]),
            .fp  (fp_n[i])
        );
    end

    // S2: FP32 results; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_fp    <= '0;
        end else begin
            if (adv2) s2_valid <= s1_valid;
            if (adv2 && s1_valid) s2_fp <= fp_n;
        end
    end

    assign r_fp     = s2_fp[IDX_R];
    assign g_fp     = s2_fp[IDX_G];
    assign b_fp     = s2_fp[IDX_B];
    assign cmax_fp  = s2_fp[IDX_CMAX];
    assign cmin_fp  = s2_fp[IDX_CMIN];
    assign delta_fp = s2_fp[IDX_DELTA];

endmodule

// File: tb/tb_rgb_fp_prep.sv
// Scoreboard bench for rgb_fp_prep: expectations are queued on every input
// transfer and compared on every output transfer; a per-cycle monitor also
// checks in_ready against the in-flight count and output stability on stall.
module tb_rgb_fp_prep;

    localparam int CH_W = 8;

    typedef struct {
        logic [31:0] r, g, b, cmax, cmin, delta;
        logic [1:0]  sel;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_r, in_g, in_b;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     r_fp, g_fp, b_fp, cmax_fp, cmin_fp, delta_fp;
    logic [1:0]      sel_obs;

    rgb_fp_prep #(.CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_fp      (r_fp),
        .g_fp      (g_fp),
        .b_fp      (b_fp),
        .cmax_fp   (cmax_fp),
        .cmin_fp   (cmin_fp),
        .delta_fp  (delta_fp)
`ifdef RGB_PREP_MAXSEL_EN
        ,
        .cmax_sel  (sel_obs)
`endif
    );

`ifndef RGB_PREP_MAXSEL_EN
    assign sel_obs = 2'd0;
`endif

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_lat = 1'b0;
    exp_t cur_exp;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %08h want %08h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference conversion: repeated halving to find the exponent.
    function automatic logic [31:0] ref_fp(input int unsigned v);
        int unsigned m;
        int          e;
        logic [31:0] man;
        if (v == 0) return 32'h0;
        m = v;
        e = 0;
        while (m >= 2) begin
            m = m / 2;
            e++;
        end
        man = (v - (32'd1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), man[22:0]};
    endfunction

    function automatic exp_t model(input int unsigned r, input int unsigned g, input int unsigned b);
        exp_t        e;
        int unsigned mx, mn;
        mx = r; mn = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        e.r = ref_fp(r); e.g = ref_fp(g); e.b = ref_fp(b);
        e.cmax = ref_fp(mx); e.cmin = ref_fp(mn); e.delta = ref_fp(mx - mn);
        if (r >= g && r >= b) e.sel = 2'd0;
        else if (g >= b)      e.sel = 2'd1;
        else                  e.sel = 2'd2;
        e.cyc = 0;
        return e;
    endfunction

    // Present one pixel and hold it until accepted (bounded).
    task automatic send(input logic [CH_W-1:0] r, input logic [CH_W-1:0] g, input logic [CH_W-1:0] b);
        bit fire;
        in_valid = 1'b1;
        in_r = r; in_g = g; in_b = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout pixel %0d,%0d,%0d not accepted in 100 cycles", r, g, b);
        in_valid = 1'b0;
    endtask

    task automatic drive(input int unsigned r, input int unsigned g, input int unsigned b);
        cur_exp = model(r, g, b);
        send(CH_W'(r), CH_W'(g), CH_W'(b));
    endtask

    // Directed pixel with the expected bundle written out by hand.
    task automatic drive_k(input int unsigned r, input int unsigned g, input int unsigned b,
                           input logic [31:0] rf, input logic [31:0] gf, input logic [31:0] bf,
                           input logic [31:0] mxf, input logic [31:0] mnf, input logic [31:0] df,
                           input logic [1:0] sel);
        cur_exp.r = rf; cur_exp.g = gf; cur_exp.b = bf;
        cur_exp.cmax = mxf; cur_exp.cmin = mnf; cur_exp.delta = df;
        cur_exp.sel = sel; cur_exp.cyc = 0;
        send(CH_W'(r), CH_W'(g), CH_W'(b));
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: sampled on the falling edge, mid-cycle between active edges.
    logic        prev_stall = 1'b0;
    logic [31:0] held [6];
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(out_ready || sb.size() < 2));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_r", r_fp, held[0]);
                chk("stall_cmax", cmax_fp, held[1]);
                chk("stall_delta", delta_fp, held[2]);
                chk("stall_cmin", cmin_fp, held[3]);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = cur_exp;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("r_fp", r_fp, e.r);
                    chk("g_fp", g_fp, e.g);
                    chk("b_fp", b_fp, e.b);
                    chk("cmax_fp", cmax_fp, e.cmax);
                    chk("cmin_fp", cmin_fp, e.cmin);
                    chk("delta_fp", delta_fp, e.delta);
`ifdef RGB_PREP_MAXSEL_EN
                    chk("cmax_sel", 32'(sel_obs), 32'(e.sel));
`endif
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            held[0] = r_fp; held[1] = cmax_fp; held[2] = delta_fp; held[3] = cmin_fp;
        end
    end

    bit rnd_done;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r = '0; in_g = '0; in_b = '0;
        cur_exp = model(0, 0, 0);

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r_fp", r_fp, 32'h0);
        chk("rst_cmax_fp", cmax_fp, 32'h0);
        chk("rst_sel", 32'(sel_obs), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed pixels with hand-written expectations, latency checked
        chk_lat = 1'b1;
        drive_k(255, 0, 0, 32'h437F0000, 32'h0, 32'h0, 32'h437F0000, 32'h0, 32'h437F0000, 2'd0);
        drive_k(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
        drive_k(10, 200, 200, 32'h41200000, 32'h43480000, 32'h43480000,
                32'h43480000, 32'h41200000, 32'h433E0000, 2'd1);
        drive_k(60, 1, 60, 32'h42700000, 32'h3F800000, 32'h42700000,
                32'h42700000, 32'h3F800000, 32'h426C0000, 2'd0);
        drive_k(7, 7, 7, 32'h40E00000, 32'h40E00000, 32'h40E00000,
                32'h40E00000, 32'h40E00000, 32'h0, 2'd0);
        drive(3, 9, 200);
        drain();

        // Stream of 8 with a 3-cycle consumer stall mid-stream
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) drive(i * 31 + 1, 255 - i * 17, (i * 77) % 256);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two pixels in flight
        drive(100, 50, 25);
        drive(1, 2, 3);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_lat = 1'b1;
        drive(40, 80, 120);
        drain();

        // Full sweep on one channel, then the other two
        for (int v = 0; v < 256; v++) drive(v, 0, 0);
        for (int v = 0; v < 256; v += 5) drive(0, v, 255 - v);
        drain();

        // Random pixels under random backpressure
        chk_lat = 1'b0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    drive($urandom_range(255), $urandom_range(255), $urandom_range(255));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
